// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write arbiter and its arbitration helper.
package rf_pkg;

  localparam int unsigned RF_ADDR_W   = 6;
  localparam int unsigned RF_DATA_W   = 64;
  localparam int unsigned RF_NUM_REGS = 64;

  typedef enum logic [1:0] {
    RFA_INIT,
    RFA_SWEEP,
    RFA_RUN
  } rfa_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 3,
  parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] pointer_i,
  input  logic            enable_i,
  output logic [N-1:0]    grant_o,
  output logic [PtrW-1:0] grant_idx_o,
  output logic            grant_valid_o
);

  int unsigned cand;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    cand          = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(pointer_i) + k) % N;
      if (enable_i && !grant_valid_o && req_i[cand]) begin
        grant_valid_o = 1'b1;
        grant_o[cand] = 1'b1;
        grant_idx_o   = PtrW'(cand);
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register-file write port: zero-sweeps after reset or clear, then round-robins
// the write requesters with a registered one-cycle write.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned ADDR_W   = RF_ADDR_W,
  parameter int unsigned DATA_W   = RF_DATA_W,
  parameter int unsigned NUM_REGS = RF_NUM_REGS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      clear_req,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      write_en,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  output logic                      init_done
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);
  localparam logic [PtrW-1:0]   LastReq  = PtrW'(NUM_REQ - 1);

  rfa_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic                write_en_q, write_en_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                arb_en;
  logic [NUM_REQ-1:0]  grant;
  logic [PtrW-1:0]     gnt_idx;
  logic                gnt_any;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   data_arr [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // A clear in RUN suppresses every grant in that same cycle.
  assign arb_en = (state_q == RFA_RUN) && !clear_req;

  rr_arbiter #(
    .N   (NUM_REQ),
    .PtrW(PtrW)
  ) u_rr_arbiter (
    .req_i        (req_valid),
    .pointer_i    (ptr_q),
    .enable_i     (arb_en),
    .grant_o      (grant),
    .grant_idx_o  (gnt_idx),
    .grant_valid_o(gnt_any)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    write_en_d = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    unique case (state_q)
      RFA_INIT: begin
        state_d = RFA_SWEEP;
      end
      RFA_SWEEP: begin
        write_en_d = 1'b1;
        waddr_d    = cnt_q;
        wdata_d    = '0;
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = RFA_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RFA_RUN: begin
        if (clear_req) begin
          state_d = RFA_SWEEP;
          cnt_d   = '0;
        end else if (gnt_any) begin
          write_en_d = 1'b1;
          waddr_d    = addr_arr[gnt_idx];
          wdata_d    = data_arr[gnt_idx];
          ptr_d      = (gnt_idx == LastReq) ? '0 : gnt_idx + 1'b1;
        end
      end
      default: begin
        state_d = RFA_INIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RFA_INIT;
      cnt_q      <= '0;
      ptr_q      <= '0;
      write_en_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      write_en_q <= write_en_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign req_ready = grant;
  assign write_en  = write_en_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign init_done = (state_q == RFA_RUN);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a behavioural register file on the write port.
module tb_rf_write_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 64;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear_req = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              write_en;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              init_done;

  logic [DW-1:0]     rf [64];

  int total = 0;
  int bad   = 0;

  rf_write_arbiter u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_req(clear_req),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ready(req_ready),
    .write_en (write_en),
    .waddr    (waddr),
    .wdata    (wdata),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_en) rf[waddr] <= wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[idx*AW +: AW] = a;
    req_data[idx*DW +: DW] = d;
  endtask

  // Expects 64 back-to-back zero writes, the first appearing after the next edge.
  task automatic expect_sweep(input string tag, input logic [NR-1:0] ready_at_end);
    for (int i = 0; i < 64; i++) begin
      step();
      check({tag, "_we"}, 64'(write_en), 64'd1);
      check({tag, "_waddr"}, 64'(waddr), 64'(i));
      check({tag, "_wdata"}, wdata, 64'd0);
      if (i < 63) begin
        check({tag, "_init_lo"}, 64'(init_done), 64'd0);
        check({tag, "_ready_lo"}, 64'(req_ready), 64'd0);
      end else begin
        check({tag, "_init_hi"}, 64'(init_done), 64'd1);
        check({tag, "_ready_end"}, 64'(req_ready), 64'(ready_at_end));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = '1;

    // 1: reset values, then the power-up sweep
    step();
    step();
    check("rst_we", 64'(write_en), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", wdata, 64'd0);
    check("rst_init", 64'(init_done), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    reset_n = 1'b1;
    step();
    check("init_we", 64'(write_en), 64'd0);
    check("init_done_lo", 64'(init_done), 64'd0);
    expect_sweep("sweep1", 3'b000);
    step();
    check("post_sweep_we", 64'(write_en), 64'd0);
    check("post_sweep_init", 64'(init_done), 64'd1);
    for (int i = 0; i < 64; i++) check("rf_zero", rf[i], 64'd0);

    // 2: single write from requester 1
    set_req(1, 6'h05, 64'hDEADBEEF_CAFEF00D);
    req_valid = 3'b010;
    #1;
    check("t2_ready", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = '0;
    check("t2_we", 64'(write_en), 64'd1);
    check("t2_waddr", 64'(waddr), 64'h05);
    check("t2_wdata", wdata, 64'hDEADBEEF_CAFEF00D);
    step();
    check("t2_rf5", rf[5], 64'hDEADBEEF_CAFEF00D);

    // pointer is 2: a lone grant to requester 2 brings it back to 0
    set_req(2, 6'h07, 64'h77);
    req_valid = 3'b100;
    #1;
    check("ptr_wrap_ready", 64'(req_ready), 64'(3'b100));
    step();
    req_valid = '0;
    check("ptr_wrap_waddr", 64'(waddr), 64'h07);

    // 3: all three valid, rotation 0,1,2,0,1,2
    set_req(0, 6'h01, 64'h100);
    set_req(1, 6'h02, 64'h200);
    set_req(2, 6'h03, 64'h300);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t3_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
      step();
      check("t3_we", 64'(write_en), 64'd1);
      check("t3_waddr", 64'(waddr), 64'((k % 3) + 1));
      check("t3_wdata", wdata, 64'(((k % 3) + 1) * 256));
    end
    req_valid = '0;
    step();
    check("t3_idle_we", 64'(write_en), 64'd0);
    check("t3_hold_waddr", 64'(waddr), 64'h03);
    check("t3_hold_wdata", wdata, 64'h300);

    // 4: clear beats a pending grant, then requester 0 wins right after the sweep
    set_req(0, 6'h2A, 64'h1234);
    req_valid = 3'b001;
    clear_req = 1'b1;
    #1;
    check("t4_ready_clr", 64'(req_ready), 64'd0);
    step();
    clear_req = 1'b0;
    check("t4_we_clr", 64'(write_en), 64'd0);
    check("t4_init_lo", 64'(init_done), 64'd0);
    expect_sweep("sweep2", 3'b001);
    step();
    req_valid = '0;
    check("t4_we", 64'(write_en), 64'd1);
    check("t4_waddr", 64'(waddr), 64'h2A);
    check("t4_wdata", wdata, 64'h1234);

    // 5: reset at sweep address 20 restarts the sweep from 0
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int i = 0; i <= 20; i++) step();
    check("t5_at20", 64'(waddr), 64'd20);
    reset_n = 1'b0;
    #1;
    check("t5_rst_we", 64'(write_en), 64'd0);
    check("t5_rst_waddr", 64'(waddr), 64'd0);
    check("t5_rst_init", 64'(init_done), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("t5_init_we", 64'(write_en), 64'd0);
    expect_sweep("sweep3", 3'b000);
    step();

    // 6: pointer 0 after reset, only requester 2 valid, then 0 and 2
    set_req(2, 6'h3F, 64'hABCD);
    req_valid = 3'b100;
    #1;
    check("t6_ready2", 64'(req_ready), 64'(3'b100));
    step();
    check("t6_waddr2", 64'(waddr), 64'h3F);
    set_req(0, 6'h11, 64'h11);
    req_valid = 3'b101;
    #1;
    check("t6_ready0", 64'(req_ready), 64'(3'b001));
    step();
    check("t6_waddr0", 64'(waddr), 64'h11);
    req_valid = 3'b100;
    #1;
    check("t6_ready2b", 64'(req_ready), 64'(3'b100));
    step();
    req_valid = '0;
    check("t6_waddr2b", 64'(waddr), 64'h3F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Owns the single write port of register_file (64 x 64-bit).
- After reset, or on a clear request, sweeps every register to zero.
- Otherwise shares the write port among NUM_REQ writers (ALU writeback, load unit, debug) using round-robin arbitration with a valid/ready handshake.
- Sits between the writeback stage and register_file; drives its write_en, waddr and wdata directly.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8)
- ADDR_W, 6, register address width
- DATA_W, 64, register data width
- NUM_REGS, 64, registers swept during clear; must equal 2**ADDR_W

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- clear_req  input  1  pulse; request a zero-sweep of all registers
- req_valid  input  NUM_REQ  per-requester write request
- req_addr  input  NUM_REQ*ADDR_W  packed; requester i at bits [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed; requester i at bits [i*DATA_W +: DATA_W]
- req_ready  output  NUM_REQ  one-hot grant; transfer when valid & ready
- write_en  output  1  to register_file write_en
- waddr  output  ADDR_W  to register_file waddr
- wdata  output  DATA_W  to register_file wdata
- init_done  output  1  high while in RUN; low during a sweep

Behaviour:
- Reset (async, reset_n=0):
  - state=INIT, sweep counter=0, round-robin pointer=0
  - write_en=0, waddr=0, wdata=0, init_done=0, req_ready=0
- FSM: INIT -> SWEEP -> RUN; RUN -> SWEEP on clear_req.
  - INIT: one cycle, then SWEEP. Absorbs reset deassertion.
  - SWEEP: each cycle registers write_en=1, waddr=counter, wdata=0; counter increments.
    - After the NUM_REGS-1 write, counter returns to 0 and state goes to RUN.
    - A sweep is exactly NUM_REGS consecutive write_en cycles, addresses 0..63 in order.
    - req_ready=0 throughout; clear_req is ignored.
  - RUN: init_done=1.
    - clear_req=1 wins over any grant that cycle: no req_ready, next state SWEEP, counter=0.
- Arbitration (RUN only):
  - req_ready is combinational: at most one bit set.
  - Grant goes to the first valid requester searching from pointer upward, with wrap-around.
  - On a grant to index g, pointer <= (g+1) mod NUM_REQ. Pointer is unchanged when nothing is granted.
- Write timing: registered, one-cycle latency.
  - Grant in cycle N gives write_en=1, waddr=req_addr[g], wdata=req_data[g] in cycle N+1.
  - With no grant, write_en=0 in the next cycle; waddr and wdata hold their previous values.
- Throughput: one write per cycle. With all requesters valid, grants rotate 0,1,2,0,…
- Requester rule: valid must stay high, with addr/data stable, until ready. The arbiter does not check this.
- Duplicate addresses in back-to-back grants are passed through in grant order; the later write wins.
- Reset mid-sweep or mid-RUN:
  - Outputs drop immediately to reset values.
  - The sweep restarts from address 0 after reset_n rises.
- After a sweep completes, the pointer is not reset; it keeps its pre-sweep value.

Decomposition:
- Package rf_pkg:
  - RF_ADDR_W=6, RF_DATA_W=64, RF_NUM_REGS=64
  - typedef enum logic [1:0] {RFA_INIT, RFA_SWEEP, RFA_RUN} rfa_state_e
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], pointer, enable
  - Outputs: one-hot grant[N], grant index
  - Purely combinational; the pointer register stays in rf_write_arbiter.
  - Reused later for the read-port arbiter.

Test Plan:
1. Reset, then release; hold req_valid=0. Expect init_done=0 and exactly 64 consecutive write_en pulses with waddr 0..63 and wdata=0. After the sweep, init_done=1. Every register_file RF[i] reads 64'h0.
2. In RUN, requester 1 asserts valid with addr=6'h05, data=64'hDEADBEEF_CAFEF00D. Expect req_ready=3'b010 that cycle, then write_en=1, waddr=5, wdata=DEADBEEFCAFEF00D the next cycle. Afterwards RF[5] matches.
3. Hold all three valid for 6 cycles (pointer=0) with addrs 1, 2, 3. Expect grant sequence 0,1,2,0,1,2, write_en high on 6 consecutive cycles, and waddr 1,2,3,1,2,3.
4. In RUN with requester 0 valid, pulse clear_req. Expect no grant that cycle, init_done to fall, and a full 64-write zero sweep. Requester 0 is granted on the first RUN cycle after the sweep.
5. Assert reset_n=0 at sweep address 20. Expect write_en=0 immediately. After release, the sweep restarts at waddr=0 and still issues 64 writes.
6. Only requester 2 valid while pointer=0. Expect an immediate grant to 2 and pointer to become 0. Next, requesters 0 and 2 valid: requester 0 is granted first.
